// File: rtl/spi_write_controller_if.sv
// Bus bundle for the SPI register-write controller: the request handshake
// from the host side plus the serial pins and status flags from the controller.
interface spi_write_controller_if;
    logic       req_valid;
    logic       req_ready;
    logic [6:0] req_addr;
    logic [7:0] req_data;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic       busy;
    logic       done;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, sclk, copi, ncs, busy, done
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, sclk, copi, ncs, busy, done
    );
endinterface

// File: rtl/spi_write_controller.sv
// SPI mode-0 register-write controller. One accepted request becomes a
// 16-bit frame {write bit, addr[6:0], data[7:0]} shifted out MSB first,
// framed by SETUP / HOLD guard times and followed by a GAP with ncs high.
// Every output is registered from the next-state values.
module spi_write_controller #(
    parameter int CLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    spi_write_controller_if.slave bus
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state;
    state_t      next_state;
    logic [7:0]  div_cnt;
    logic [3:0]  bit_cnt;
    logic [15:0] shreg;
    logic [15:0] shreg_next;

    logic sclk_q, copi_q, ncs_q, busy_q, done_q, ready_q;
    logic sclk_d, copi_d, ncs_d, busy_d, done_d, ready_d;

    logic div_end;
    logic accept;
    logic fall_evt;
    logic last_low;

    assign div_end  = (div_cnt == DIV_LAST);
    assign accept   = (state == IDLE) && bus.req_valid && ready_q;
    assign fall_evt = (state == SHIFT) && div_end && sclk_q;
    assign last_low = (state == SHIFT) && div_end && !sclk_q && (bit_cnt == 4'd15);

    // State register; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: every timed phase ends when the divider wraps,
    // SHIFT only after the low half of the sixteenth bit.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept)   next_state = SETUP;
            SETUP:   if (div_end)  next_state = SHIFT;
            SHIFT:   if (last_low) next_state = HOLD;
            HOLD:    if (div_end)  next_state = GAP;
            GAP:     if (div_end)  next_state = IDLE;
            default:               next_state = IDLE;
        endcase
    end

    // Divider and bit counters; the divider restarts on every state change
    // so nothing carries from one frame or phase into the next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            if (state == IDLE || next_state != state || div_end) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end

            if (state != SHIFT) begin
                bit_cnt <= '0;
            end else if (div_end && !sclk_q && bit_cnt != 4'd15) begin
                bit_cnt <= bit_cnt + 4'd1;
            end

            shreg <= shreg_next;
        end
    end

    // Output logic: frame loads on accept and shifts on each sclk fall,
    // pins are derived from the state being entered so they register cleanly.
    always_comb begin
        shreg_next = shreg;
        if (accept) begin
            shreg_next = {1'b1, bus.req_addr, bus.req_data};
        end else if (fall_evt) begin
            shreg_next = {shreg[14:0], 1'b0};
        end else if (next_state == IDLE) begin
            shreg_next = '0;
        end

        sclk_d = 1'b0;
        if (next_state == SHIFT) begin
            if (state != SHIFT) begin
                sclk_d = 1'b1;
            end else if (div_end) begin
                sclk_d = ~sclk_q;
            end else begin
                sclk_d = sclk_q;
            end
        end

        copi_d  = (next_state == SETUP || next_state == SHIFT) ? shreg_next[15] : 1'b0;
        ncs_d   = !(next_state == SETUP || next_state == SHIFT || next_state == HOLD);
        busy_d  = (next_state != IDLE);
        done_d  = (next_state == GAP) && (state == HOLD);
        ready_d = (next_state == IDLE);
    end

    // Output registers; reset forces the idle pin levels immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q  <= 1'b0;
            copi_q  <= 1'b0;
            ncs_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            sclk_q  <= sclk_d;
            copi_q  <= copi_d;
            ncs_q   <= ncs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign bus.sclk      = sclk_q;
    assign bus.copi      = copi_q;
    assign bus.ncs       = ncs_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.req_ready = ready_q;

endmodule

// File: tb/tb_spi_write_controller.sv
// Bench for spi_write_controller: two instances (CLK_DIV 4 and 2) share a
// clock and reset. A driver pushes the expected frame into a queue on each
// accept; a pin monitor rebuilds frames from copi at sclk rises and pops.
module tb_spi_write_controller;

    logic clk;
    logic rst_n;

    spi_write_controller_if if4();
    spi_write_controller_if if2();

    spi_write_controller #(.CLK_DIV(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    spi_write_controller #(.CLK_DIV(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    typedef struct {
        int          sel;
        logic [6:0]  addr;
        logic [7:0]  data;
        logic [15:0] exp_frame;
    } vec_t;

    vec_t vecs[5];

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];

    int          bits_cnt[2]    = '{0, 0};
    logic [15:0] shift_in[2]    = '{16'h0, 16'h0};
    int          low_cnt[2]     = '{0, 0};
    int          high_cnt[2]    = '{0, 0};
    int          viol[2]        = '{0, 0};
    int          frames_done[2] = '{0, 0};
    int          done_total[2]  = '{0, 0};
    int          exp_frames[2]  = '{0, 0};
    bit          in_frame[2]    = '{1'b0, 1'b0};
    bit          have_prev[2]   = '{1'b0, 1'b0};
    logic        prev_s[2]      = '{1'b0, 1'b0};
    logic        prev_c[2]      = '{1'b0, 1'b0};
    logic        prev_n[2]      = '{1'b1, 1'b1};

    // Free-running system clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkAtLeast(input string name, input int actual, input int minimum);
        n_checks++;
        if (actual < minimum) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected at least %0d", name, actual, minimum);
        end
    endtask

    task automatic driveReq(input int d, input logic v, input logic [6:0] a, input logic [7:0] dt);
        if (d == 0) begin
            if4.req_valid = v;
            if4.req_addr  = a;
            if4.req_data  = dt;
        end else begin
            if2.req_valid = v;
            if2.req_addr  = a;
            if2.req_data  = dt;
        end
    endtask

    function automatic logic getReady(input int d);
        return (d == 0) ? if4.req_ready : if2.req_ready;
    endfunction

    task automatic applyStimulus(input int d, input logic [6:0] a, input logic [7:0] dt,
                                 input logic [15:0] exp_frame, input bit hold_valid, input bit scramble);
        bit got;
        got = 1'b0;
        @(negedge clk);
        driveReq(d, 1'b1, a, dt);
        for (int i = 0; i < 2000; i++) begin
            if (getReady(d)) begin
                if (d == 0) exp_q0.push_back(exp_frame);
                else        exp_q1.push_back(exp_frame);
                exp_frames[d]++;
                @(posedge clk);
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) checkOutput($sformatf("accept_timeout_d%0d", d), 32'd0, 32'd1);
        #1;
        if (scramble) driveReq(d, hold_valid, 7'($urandom), 8'($urandom));
        else if (!hold_valid) driveReq(d, 1'b0, a, dt);
    endtask

    task automatic waitFrames(input int d);
        bit reached;
        reached = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            #1;
            if (frames_done[d] >= exp_frames[d]) begin
                reached = 1'b1;
                break;
            end
        end
        if (!reached) checkOutput($sformatf("frame_timeout_d%0d", d), 32'(frames_done[d]), 32'(exp_frames[d]));
    endtask

    task automatic monitorStep(input int d, input logic s, input logic c, input logic n, input logic dn);
        int div;
        logic [15:0] exp;
        div = (d == 0) ? 4 : 2;
        if (!rst_n) begin
            in_frame[d]  = 1'b0;
            have_prev[d] = 1'b0;
            bits_cnt[d]  = 0;
            shift_in[d]  = '0;
            low_cnt[d]   = 0;
            high_cnt[d]  = 0;
            viol[d]      = 0;
        end else begin
            if (dn) done_total[d]++;
            if (prev_n[d] && !n) begin
                if (have_prev[d]) checkAtLeast($sformatf("ncs_gap_d%0d", d), high_cnt[d], div + 1);
                in_frame[d] = 1'b1;
                bits_cnt[d] = 0;
                shift_in[d] = '0;
                low_cnt[d]  = 0;
                viol[d]     = 0;
            end
            if (!n) low_cnt[d]++;
            else    high_cnt[d]++;
            if (in_frame[d] && !n && !prev_s[d] && s) begin
                shift_in[d] = {shift_in[d][14:0], c};
                bits_cnt[d]++;
            end
            if (in_frame[d] && prev_s[d] && s && (c !== prev_c[d])) viol[d]++;
            if (in_frame[d] && !prev_n[d] && n) begin
                if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
                    checkOutput($sformatf("unexpected_frame_d%0d", d), 32'(shift_in[d]), 32'hFFFF_FFFF);
                end else begin
                    exp = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    checkOutput($sformatf("frame_d%0d", d), 32'(shift_in[d]), 32'(exp));
                end
                checkOutput($sformatf("sclk_rises_d%0d", d), 32'(bits_cnt[d]), 32'd16);
                checkOutput($sformatf("ncs_low_d%0d", d), 32'(low_cnt[d]), 32'(34 * div));
                checkOutput($sformatf("copi_stable_d%0d", d), 32'(viol[d]), 32'd0);
                checkOutput($sformatf("done_at_end_d%0d", d), 32'(dn), 32'd1);
                checkOutput($sformatf("copi_idle_d%0d", d), 32'(c), 32'd0);
                frames_done[d]++;
                in_frame[d]  = 1'b0;
                have_prev[d] = 1'b1;
                high_cnt[d]  = 1;
            end
        end
        prev_s[d] = s;
        prev_c[d] = c;
        prev_n[d] = n;
    endtask

    // Pin monitor for both instances, sampled on the falling clk edge.
    always @(negedge clk) begin
        monitorStep(0, if4.sclk, if4.copi, if4.ncs, if4.done);
        monitorStep(1, if2.sclk, if2.copi, if2.ncs, if2.done);
    end

    // Main test sequence.
    initial begin
        int done_before;
        int frames_before;
        bit hit;
        logic [6:0] a1, a2;
        logic [7:0] d1, d2;

        vecs[0] = '{sel: 0, addr: 7'h00, data: 8'hFF, exp_frame: 16'h80FF};
        vecs[1] = '{sel: 1, addr: 7'h7F, data: 8'h5A, exp_frame: 16'hFF5A};
        vecs[2] = '{sel: 0, addr: 7'h2A, data: 8'h3C, exp_frame: 16'hAA3C};
        vecs[3] = '{sel: 0, addr: 7'h55, data: 8'hA5, exp_frame: 16'hD5A5};
        vecs[4] = '{sel: 1, addr: 7'h01, data: 8'h80, exp_frame: 16'h8180};

        rst_n = 1'b0;
        driveReq(0, 1'b0, 7'h0, 8'h0);
        driveReq(1, 1'b0, 7'h0, 8'h0);
        repeat (3) @(negedge clk);
        checkOutput("rst_ncs",   32'(if4.ncs),       32'd1);
        checkOutput("rst_sclk",  32'(if4.sclk),      32'd0);
        checkOutput("rst_copi",  32'(if4.copi),      32'd0);
        checkOutput("rst_done",  32'(if4.done),      32'd0);
        checkOutput("rst_busy",  32'(if4.busy),      32'd0);
        checkOutput("rst_ready", 32'(if4.req_ready), 32'd0);
        checkOutput("rst_ready_d1", 32'(if2.req_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("ready_before_edge", 32'(if4.req_ready), 32'd0);
        @(negedge clk);
        checkOutput("ready_after_release",    32'(if4.req_ready), 32'd1);
        checkOutput("ready_after_release_d1", 32'(if2.req_ready), 32'd1);
        checkOutput("ncs_after_release",      32'(if4.ncs),       32'd1);

        $display("[TB] table-driven frames");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].sel, vecs[i].addr, vecs[i].data, vecs[i].exp_frame, 1'b0, 1'b1);
            waitFrames(vecs[i].sel);
            repeat (10) @(negedge clk);
        end

        $display("[TB] back-to-back with held valid");
        a1 = 7'h3E; d1 = 8'hC3;
        a2 = 7'h41; d2 = 8'h18;
        applyStimulus(0, a1, d1, {1'b1, a1, d1}, 1'b1, 1'b1);
        applyStimulus(0, a2, d2, {1'b1, a2, d2}, 1'b0, 1'b1);
        waitFrames(0);
        repeat (10) @(negedge clk);

        $display("[TB] request while busy");
        applyStimulus(0, 7'h33, 8'h66, 16'hB366, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            driveReq(0, 1'b1, 7'h0F, 8'hF0);
            checkOutput("ready_while_busy", 32'(if4.req_ready), 32'd0);
            checkOutput("busy_flag",        32'(if4.busy),      32'd1);
            @(negedge clk);
        end
        driveReq(0, 1'b0, 7'h0, 8'h0);
        waitFrames(0);
        repeat (40) @(negedge clk);
        checkOutput("no_extra_frame", 32'(frames_done[0]), 32'(exp_frames[0]));
        checkOutput("queue_drained",  32'(exp_q0.size()),  32'd0);

        $display("[TB] reset mid-frame");
        applyStimulus(0, 7'h12, 8'h34, 16'h9234, 1'b0, 1'b1);
        hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #2;
            if (bits_cnt[0] >= 7) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) checkOutput("seven_rises_timeout", 32'(bits_cnt[0]), 32'd7);
        done_before   = done_total[0];
        frames_before = frames_done[0];
        rst_n = 1'b0;
        #1;
        checkOutput("abort_ncs",  32'(if4.ncs),  32'd1);
        checkOutput("abort_sclk", 32'(if4.sclk), 32'd0);
        checkOutput("abort_busy", 32'(if4.busy), 32'd0);
        repeat (2) @(negedge clk);
        exp_q0.delete();
        exp_frames[0] = frames_before;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("abort_no_done",   32'(done_total[0]),  32'(done_before));
        checkOutput("abort_no_frame",  32'(frames_done[0]), 32'(frames_before));
        applyStimulus(0, 7'h12, 8'h34, 16'h9234, 1'b0, 1'b1);
        waitFrames(0);
        repeat (10) @(negedge clk);

        checkOutput("done_count_d0", 32'(done_total[0]), 32'(frames_done[0]));
        checkOutput("done_count_d1", 32'(done_total[1]), 32'(frames_done[1]));

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
